hazard_scoreboard: RTL
======================

// Module: hazard_scoreboard
// PURPOSE
//  Producer side of the EX-stage operand bypass. Tracks in-flight destination registers in EX/MEM/WB.
//  Drives rd_mem/rd_wb/regwrite_mem/regwrite_wb, which the forwarding unit consumes.
//  Detects hazards that bypassing cannot cover and stalls the front end: load-use and multi-cycle
//  (mul/div) EX occupancy. Inserts bubbles into ID/EX. Sits beside the ID stage in the 5-stage pipeline.
// PARAMETERS
//  REG_AW  5  register address width
//  MC_LAT  4  EX residency in cycles of a multi-cycle op; legal range 1..15; 1 = ordinary single-cycle op
// PORTS
//  clk            in   1       pipeline clock, rising edge
//  reset_n        in   1       asynchronous, active-low reset
//  id_valid       in   1       ID holds a real instruction
//  id_rs1,id_rs2  in   REG_AW  ID source registers
//  id_use_rs1/2   in   1       instruction reads rs1 / rs2
//  id_rd          in   REG_AW  ID destination register
//  id_regwrite    in   1       ID instruction writes rd
//  id_memread     in   1       ID instruction is a load
//  id_multicycle  in   1       ID instruction is mul/div
//  flush          in   1       branch taken in EX; kill IF/ID contents
//  stall          out  1       hold PC and IF/ID (combinational)
//  bubble         out  1       ID/EX loads a NOP this edge (combinational)
//  mc_busy        out  1       multi-cycle op occupying EX (registered)
//  rd_ex,rd_mem,rd_wb  out  REG_AW   destination tags per stage (registered)
//  regwrite_ex/mem/wb  out  1        write-enable tags per stage (registered)
// BEHAVIOUR
//  - Reset (reset_n=0, async): all slot tags and regwrites 0, counter 0, mc_busy 0.
//    stall=bubble=0 while in reset and on the first cycle after it.
//  - Slots EX,MEM,WB each hold {valid,rd,regwrite,memread}. A slot with rd==0 has regwrite forced to 0.
//  - load_use = EX.valid & EX.memread & EX.regwrite & id_valid &
//    ((id_use_rs1 & id_rs1==EX.rd) | (id_use_rs2 & id_rs2==EX.rd)).
//  - Counter cnt (4b): loaded with MC_LAT-1 when a multicycle instr enters EX.
//    Decrements while nonzero. mc_busy = (cnt!=0).
//  - stall = (load_use | mc_busy) & ~flush.
//  - bubble = load_use | flush.
//  - Per edge, priority order:
//    1) mc_busy: EX holds; MEM <= invalid; WB <= MEM; cnt--.
//    2) otherwise: WB <= MEM; MEM <= EX; EX <= bubble ? invalid : ID fields (valid=id_valid).
//  - flush arriving while mc_busy=1 is illegal (a branch cannot sit in EX with mul/div); assertion fires.
//  - MC_LAT=1: cnt loads 0, no stall; behaves as a single-cycle op.
//  - Load-use stall lasts exactly one cycle. The next cycle the load is in MEM and forwarding covers it.
//  - Multi-cycle op: MC_LAT-1 stall cycles. Its result appears in rd_mem on cycle MC_LAT after EX entry.
//  - Back-to-back multicycle ops: the second enters EX the edge after the first leaves.
//    cnt reloads on that edge; no gap cycle.
//  - Dependent on multicycle result: no extra stall; the bypass from MEM covers it.
//  - reset_n deasserted mid multi-cycle op: counter and slots clear immediately; pipeline empty.
// TESTING
//  1 reset: reset_n=0 with random inputs -> all outputs 0; release -> stall=0 with id_valid=0.
//  2 load-use: lw x5 in EX, ID add x6,x5,x1 (use_rs1) -> stall=1, bubble=1 one cycle.
//    Next cycle rd_mem=5, regwrite_mem=1, stall=0.
//  3 no false hazard: lw x0 in EX, ID reads x0 -> stall=0.
//    lw x5 in EX, ID reads x5 with use_rs1=0 -> stall=0.
//  4 multicycle MC_LAT=4: mul x7 enters EX -> mc_busy=1 and stall=1 for 3 cycles, MEM slot empty.
//    Cycle 4: rd_mem=7, regwrite_mem=1.
//  5 flush beats load-use: flush=1 together with load_use -> stall=0, bubble=1.
//    EX slot invalid next edge; older MEM/WB advance normally.
//  6 mid-op reset: assert reset_n=0 at cnt=2 -> mc_busy, rd_*, regwrite_* all 0 asynchronously.
//    Then repeat MC_LAT=1 run -> never stalls.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Destination-tag scoreboard for the EX/MEM/WB stages of a 5-stage pipeline.
// Raises stall/bubble for load-use and multi-cycle EX occupancy hazards.
module hazard_scoreboard_chk #(
  parameter int SW = 8
) (
  input logic          clk,
  input logic          reset_n,
  input logic          flush,
  input logic          mc_busy,
  input logic [SW-1:0] ex_s,
  input logic [SW-1:0] mem_s,
  input logic [SW-1:0] wb_s
);
  // slot layout: {valid, rd, regwrite, memread}
  function automatic logic slot_ok(input logic [SW-1:0] s);
    return (s[SW-1] || (s == '0)) && (!s[1] || (s[SW-2:2] != '0));
  endfunction

  a_no_flush_when_busy: assert property (@(posedge clk) disable iff (!reset_n) !(flush && mc_busy));
  a_ex_slot_ok:  assert property (@(posedge clk) disable iff (!reset_n) slot_ok(ex_s));
  a_mem_slot_ok: assert property (@(posedge clk) disable iff (!reset_n) slot_ok(mem_s));
  a_wb_slot_ok:  assert property (@(posedge clk) disable iff (!reset_n) slot_ok(wb_s));
endmodule

module hazard_scoreboard #(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_multicycle,
  input  logic              flush,
  output logic              stall,
  output logic              bubble,
  output logic              mc_busy,
  output logic [REG_AW-1:0] rd_ex,
  output logic [REG_AW-1:0] rd_mem,
  output logic [REG_AW-1:0] rd_wb,
  output logic              regwrite_ex,
  output logic              regwrite_mem,
  output logic              regwrite_wb
);
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } slot_t;

  localparam logic [3:0] MC_LOAD = 4'(MC_LAT - 1);

  slot_t      ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, id_slot_s;
  logic [3:0] cnt_q, cnt_d;
  logic       live_q;
  logic       load_use_s;

  // ID instruction as a slot: invalid slots are all-zero and rd==0 never writes
  always_comb begin
    id_slot_s = '0;
    if (id_valid) begin
      id_slot_s.valid    = 1'b1;
      id_slot_s.rd       = id_rd;
      id_slot_s.regwrite = id_regwrite & (id_rd != '0);
      id_slot_s.memread  = id_memread;
    end else begin
      id_slot_s = '0;
    end
  end

  // Load in EX feeding a source that ID actually reads
  always_comb begin
    load_use_s = ex_q.valid & ex_q.memread & ex_q.regwrite & id_valid &
                 ((id_use_rs1 & (id_rs1 == ex_q.rd)) | (id_use_rs2 & (id_rs2 == ex_q.rd)));
  end

  assign mc_busy = (cnt_q != 4'd0);
  // live_q holds stall/bubble low through reset and the first cycle after it
  assign stall   = live_q & (load_use_s | mc_busy) & ~flush;
  assign bubble  = live_q & (load_use_s | flush);

  // Slot advance: a busy multi-cycle op pins EX and drains a hole into MEM
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    cnt_d = cnt_q;
    if (mc_busy) begin
      mem_d = '0;
      wb_d  = mem_q;
      cnt_d = cnt_q - 4'd1;
    end else begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (bubble) begin
        ex_d = '0;
      end else begin
        ex_d = id_slot_s;
      end
      if (!bubble && id_slot_s.valid && id_multicycle) begin
        cnt_d = MC_LOAD;
      end else begin
        cnt_d = 4'd0;
      end
    end
  end

  // Pipeline tag registers and occupancy counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q   <= '0;
      mem_q  <= '0;
      wb_q   <= '0;
      cnt_q  <= 4'd0;
      live_q <= 1'b0;
    end else begin
      ex_q   <= ex_d;
      mem_q  <= mem_d;
      wb_q   <= wb_d;
      cnt_q  <= cnt_d;
      live_q <= 1'b1;
    end
  end

  assign rd_ex        = ex_q.rd;
  assign rd_mem       = mem_q.rd;
  assign rd_wb        = wb_q.rd;
  assign regwrite_ex  = ex_q.regwrite;
  assign regwrite_mem = mem_q.regwrite;
  assign regwrite_wb  = wb_q.regwrite;

  hazard_scoreboard_chk #(.SW(REG_AW + 3)) u_chk (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .mc_busy (mc_busy),
    .ex_s    (ex_q),
    .mem_s   (mem_q),
    .wb_s    (wb_q)
  );
endmodule
